slow_divider: RTL and testbench

Sequential restoring (shift-subtract) unsigned integer divider that produces one quotient bit per clock.
- A one-cycle start pulse launches a division of X by Y.
- After WIDTH iteration cycles, quot and rem are presented with a valid level.
- Used as a small, area-cheap arithmetic unit where multi-cycle latency is acceptable.

---
 rtl/slow_divider_pkg.sv | 12 +
 rtl/slow_divider_if.sv | 20 ++
 rtl/slow_divider_step.sv | 22 ++
 rtl/slow_divider.sv | 116 +++++++++++
 tb/tb_slow_divider.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/slow_divider_pkg.sv
// Shared types and defaults for the slow_divider restoring divider.
package slow_divider_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slow_divider_if.sv
// Request/result bundle for slow_divider; SLOW_DIV_DBZ_EN adds the dbz flag.
interface slow_divider_if #(
  parameter int unsigned WIDTH = slow_divider_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             valid;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
`ifdef SLOW_DIV_DBZ_EN
  logic             dbz;

  modport master (output start, X, Y, input valid, quot, rem, dbz);
  modport slave  (input start, X, Y, output valid, quot, rem, dbz);
`else
  modport master (output start, X, Y, input valid, quot, rem);
  modport slave  (input start, X, Y, output valid, quot, rem);
`endif
endinterface

// File: rtl/slow_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module slow_divider_step #(
  parameter int unsigned WIDTH = slow_divider_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] part_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] part_o,
  output logic             qbit_o
);
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // The difference always fits WIDTH bits when the compare succeeds, so the
  // subtraction can be done at WIDTH bits while the compare uses WIDTH+1.
  always_comb begin
    trial  = {part_i, msb_i};
    qbit_o = (trial >= {1'b0, dvs_i});
    diff   = trial[WIDTH-1:0] - dvs_i;
    part_o = qbit_o ? diff : trial[WIDTH-1:0];
  end
endmodule

// File: rtl/slow_divider.sv
// Sequential shift-subtract unsigned divider, one quotient bit per cycle.
// Define SLOW_DIV_DBZ_EN to add the divide-by-zero flag on the interface.
module slow_divider
  import slow_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  slow_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
`ifdef SLOW_DIV_DBZ_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH-1:0] part_nxt;
  logic             qbit;

  slow_divider_step #(.WIDTH(WIDTH)) u_step (
    .part_i (part_q),
    .msb_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .part_o (part_nxt),
    .qbit_o (qbit)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    valid_d = valid_q;
`ifdef SLOW_DIV_DBZ_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvd_d   = bus.X;
          dvs_d   = bus.Y;
          part_d  = '0;
          cnt_d   = CW'(WIDTH);
          valid_d = 1'b0;
`ifdef SLOW_DIV_DBZ_EN
          dbz_d   = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        dvd_d  = {dvd_q[WIDTH-2:0], qbit};
        part_d = part_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = {dvd_q[WIDTH-2:0], qbit};
          rem_d   = part_nxt;
          valid_d = 1'b1;
`ifdef SLOW_DIV_DBZ_EN
          dbz_d   = (dvs_q == '0);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
`ifdef SLOW_DIV_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
`ifdef SLOW_DIV_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.valid = valid_q;
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_q;
`ifdef SLOW_DIV_DBZ_EN
  assign bus.dbz   = dbz_q;
`endif
endmodule

// File: tb/tb_slow_divider.sv
// Self-checking bench for slow_divider; covers the dbz flag when SLOW_DIV_DBZ_EN is defined.
module tb_slow_divider;
  localparam int W = 4;
  localparam int ONES = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   fails = 0;
  int   last_q = 0;
  int   last_r = 0;

  always #5 clk = ~clk;

  slow_divider_if #(.WIDTH(W)) bus ();

  slow_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int ref_quot(input int x, input int y);
    return (y == 0) ? ONES : x / y;
  endfunction

  function automatic int ref_rem(input int x, input int y);
    return (y == 0) ? x : x % y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One division from an idle/done state; optionally re-pulse start (X=1,Y=1) while busy.
  task automatic run_div(input int x, input int y, input bit interfere);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X = W'(x);
    bus.Y = W'(y);
    @(negedge clk);
    bus.start = 1'b0;
    check("accept_valid_low", bus.valid, 0);
    check("held_quot", bus.quot, last_q);
    check("held_rem", bus.rem, last_r);
`ifdef SLOW_DIV_DBZ_EN
    check("dbz_cleared", bus.dbz, 0);
`endif
    for (int k = 2; k <= W; k++) begin
      @(negedge clk);
      bus.start = interfere && (k == 2);
      if (interfere && k == 2) begin
        bus.X = W'(1);
        bus.Y = W'(1);
      end
      check("busy_valid_low", bus.valid, 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_valid", bus.valid, 1);
    check("done_quot", bus.quot, ref_quot(x, y));
    check("done_rem", bus.rem, ref_rem(x, y));
`ifdef SLOW_DIV_DBZ_EN
    check("done_dbz", bus.dbz, (y == 0) ? 1 : 0);
`endif
    last_q = ref_quot(x, y);
    last_r = ref_rem(x, y);
    @(negedge clk);
    check("hold_valid", bus.valid, 1);
    check("hold_quot", bus.quot, last_q);
    check("hold_rem", bus.rem, last_r);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    #12;
    check("rst_valid", bus.valid, 0);
    check("rst_quot", bus.quot, 0);
    check("rst_rem", bus.rem, 0);
`ifdef SLOW_DIV_DBZ_EN
    check("rst_dbz", bus.dbz, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    run_div(15, 8, 1'b0);
    run_div(10, 2, 1'b0);
    run_div(3, 7, 1'b0);
    run_div(15, 1, 1'b0);
    run_div(0, 5, 1'b0);
    run_div(9, 0, 1'b0);
    run_div(14, 3, 1'b1);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X = W'(14);
    bus.Y = W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", bus.valid, 0);
    check("async_rst_quot", bus.quot, 0);
    check("async_rst_rem", bus.rem, 0);
    @(negedge clk);
    rst = 1'b1;
    last_q = 0;
    last_r = 0;
    run_div(12, 5, 1'b0);

    // start held high: the next request is accepted on the completion edge's successor.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X = W'(13);
    bus.Y = W'(4);
    @(negedge clk);
    bus.X = W'(11);
    bus.Y = W'(2);
    for (int k = 2; k <= W + 1; k++) @(negedge clk);
    check("b2b_first_valid", bus.valid, 1);
    check("b2b_first_quot", bus.quot, ref_quot(13, 4));
    check("b2b_first_rem", bus.rem, ref_rem(13, 4));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_second_accept", bus.valid, 0);
    for (int k = 2; k <= W + 1; k++) @(negedge clk);
    check("b2b_second_valid", bus.valid, 1);
    check("b2b_second_quot", bus.quot, ref_quot(11, 2));
    check("b2b_second_rem", bus.rem, ref_rem(11, 2));
    last_q = ref_quot(11, 2);
    last_r = ref_rem(11, 2);

    for (int i = 0; i < 16; i++) begin
      run_div(int'($urandom_range(0, ONES)), int'($urandom_range(0, ONES)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
